// File: rtl/cpu_defs.sv
// Shared widths, constants and address helpers for the pipelined MIPS CPU.
package cpu_defs;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Reduce a byte address into a power-of-two word memory and force word alignment.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] addr,
                                                  input int unsigned words);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'(words * 4 - 1);
    mask[1:0] = 2'b00;
    return addr & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, feeds the IF/ID register, handles
// stalls and redirects, and keeps fetch/stall performance counters.
module fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter int          CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc_addr_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [ADDR_W-1:0]  ifid_pc4_o,
  output logic               ifid_valid_o,
  output logic [CNT_W-1:0]   fetch_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  logic [ADDR_W-1:0]  pc_p0;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] instr_p1;
  logic [ADDR_W-1:0]  pc4_p1;
  logic               vld_p1;
  logic               fetch_inc;
  logic               stall_inc;

  assign pc_next   = wrap_addr(pc_p0 + 32'd4, IMEM_WORDS);
  assign fetch_inc = !redirect_i && !stall_i;
  assign stall_inc = !redirect_i && stall_i;

  // IF -> ID boundary: redirect flushes to a bubble, stall holds, else advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_p0    <= RESET_PC;
      instr_p1 <= NOP_INSTR;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (redirect_i) begin
      pc_p0    <= wrap_addr(redirect_pc_i, IMEM_WORDS);
      instr_p1 <= NOP_INSTR;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (!stall_i) begin
      pc_p0    <= pc_next;
      instr_p1 <= instr_i;
      pc4_p1   <= pc_next;
      vld_p1   <= 1'b1;
    end
  end

  assign pc_addr_o    = pc_p0;
  assign ifid_instr_o = instr_p1;
  assign ifid_pc4_o   = pc4_p1;
  assign ifid_valid_o = vld_p1;

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .inc (fetch_inc),
    .cnt (fetch_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .inc (stall_inc),
    .cnt (stall_cnt_o)
  );

endmodule
